// File: rtl/burst_memory_pkg.sv
// Shared types and default sizing for the burst memory.
package burst_memory_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } state_e;

  localparam int unsigned DefWordSize = 8;
  localparam int unsigned DefLen      = 65536;
  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefBurstW   = 4;

endpackage

// File: rtl/burst_memory_array.sv
// Storage array: synchronous write, combinational read, no reset.
module burst_memory_array
  import burst_memory_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DefWordSize,
  parameter int unsigned LEN       = DefLen,
  parameter int unsigned ADDR_W    = DefAddrW
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [WORD_SIZE-1:0] rdata_o
);

  // Addresses are always kept below LEN, so only the low index bits matter.
  localparam int unsigned IdxW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [WORD_SIZE-1:0] mem_q [LEN];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i[IdxW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i[IdxW-1:0]];

endmodule

// File: rtl/burst_memory.sv
// Burst-oriented memory: one command channel, write-data and read-data streams.
module burst_memory
  import burst_memory_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DefWordSize,
  parameter int unsigned LEN       = DefLen,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned BURST_W   = DefBurstW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [BURST_W-1:0]   req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_last,
  output logic                 busy
);

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BURST_W-1:0]   cnt_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic [WORD_SIZE-1:0] rd_data_q;

  logic                 accept;
  logic                 wr_beat;
  logic                 rd_load;
  logic                 rd_drain;
  logic                 rd_last_d;
  logic [ADDR_W-1:0]    req_addr_mod;
  logic [ADDR_W-1:0]    mem_raddr;
  logic [ADDR_W-1:0]    addr_next;
  logic [WORD_SIZE-1:0] mem_rdata;

  // Handshake decode and address arithmetic.
  always_comb begin
    // Gating with reset keeps req_ready low while reset is held.
    req_ready    = reset && (state_q == StIdle) && !rd_valid_q;
    accept       = req_valid && req_ready;
    req_addr_mod = ADDR_W'(32'(req_addr) % LEN);
    // In IDLE the first read word is fetched straight from the request address,
    // giving rd_valid in the cycle after accept.
    mem_raddr    = (state_q == StIdle) ? req_addr_mod : addr_q;
    addr_next    = (mem_raddr == ADDR_W'(LEN - 1)) ? '0 : mem_raddr + ADDR_W'(1);
    wr_beat      = (state_q == StWrite) && wr_valid;
    rd_drain     = rd_valid_q && rd_ready;
    rd_load      = (accept && !req_write) ||
                   ((state_q == StRead) && (!rd_valid_q || rd_ready));
    rd_last_d    = (state_q == StIdle) ? (req_len == '0) : (cnt_q == '0);
  end

  // Control FSM with address/count tracking and the read output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (rd_drain) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
      if (rd_load) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= mem_rdata;
        rd_last_q  <= rd_last_d;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (req_write) begin
              state_q <= StWrite;
              addr_q  <= req_addr_mod;
              cnt_q   <= req_len;
            end else begin
              // First word already loaded this edge.
              addr_q <= addr_next;
              if (req_len != '0) begin
                state_q <= StRead;
                cnt_q   <= req_len - BURST_W'(1);
              end
            end
          end
        end
        StWrite: begin
          if (wr_beat) begin
            addr_q <= addr_next;
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - BURST_W'(1);
            end
          end
        end
        StRead: begin
          if (rd_load) begin
            addr_q <= addr_next;
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - BURST_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_ready = (state_q == StWrite);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign busy     = (state_q != StIdle) || rd_valid_q;

  burst_memory_array #(
    .WORD_SIZE (WORD_SIZE),
    .LEN       (LEN),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (wr_beat),
    .waddr_i (addr_q),
    .wdata_i (wr_data),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_burst_memory.sv
// Randomized bench for burst_memory against an array-based memory model.
module tb_burst_memory;

  localparam int WS  = 8;
  localparam int LEN = 100;
  localparam int AW  = 8;
  localparam int BW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_len;
  logic          wr_valid, wr_ready;
  logic [WS-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last, busy;
  logic [WS-1:0] rd_data;

  int n_total = 0;
  int n_bad   = 0;
  int mem_m [LEN];
  logic [WS-1:0] wq [$];

  burst_memory #(
    .WORD_SIZE (WS),
    .LEN       (LEN),
    .ADDR_W    (AW),
    .BURST_W   (BW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    int cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, 32'(cyc < 50), 32'(1));
    @(posedge clk); #1;
  endtask

  // Write burst; queued words are used first, then random data.
  task automatic do_write(input int addr, input int len, input int gap_pct);
    int a = addr % LEN;
    int beats = 0;
    int cyc = 0;
    logic [WS-1:0] d;
    req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(addr); req_len = BW'(len);
    wait_accept("w_accept");
    req_valid = 1'b0;
    while (beats <= len && cyc < 200) begin
      check("w_wr_ready", 32'(wr_ready), 32'(1));
      check("w_req_ready_low", 32'(req_ready), 32'(0));
      wr_valid = (int'($urandom_range(99)) >= gap_pct);
      if (wr_valid && wq.size() > 0) d = wq.pop_front();
      else d = WS'($urandom);
      wr_data = d;
      @(posedge clk); #1;
      cyc++;
      if (wr_valid) begin
        mem_m[a] = int'(d);
        a = (a + 1) % LEN;
        beats++;
      end
    end
    wr_valid = 1'b0;
    check("w_beats", 32'(beats), 32'(len + 1));
    check("w_idle_ready", 32'(req_ready), 32'(1));
    check("w_wr_ready_low", 32'(wr_ready), 32'(0));
  endtask

  // Read burst. mode 1: rd_ready always high, 2: pattern 1,0,0 repeating, 3: random.
  // keep_req holds req_valid high with a follow-on write command queued.
  task automatic do_read(input int addr, input int len, input int mode, input bit keep_req,
                         input int nxt_addr, input int nxt_len);
    int a = addr % LEN;
    int idx = 0;
    int cyc = 0;
    int k = 0;
    bit stalled = 1'b0;
    logic [WS-1:0] prev = '0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(addr); req_len = BW'(len);
    wait_accept("r_accept");
    if (keep_req) begin
      req_write = 1'b1; req_addr = AW'(nxt_addr); req_len = BW'(nxt_len);
    end else begin
      req_valid = 1'b0;
    end
    check("r_latency", 32'(rd_valid), 32'(1));
    while (idx <= len && cyc < 300) begin
      if (rd_valid) begin
        if (mem_m[(a + idx) % LEN] >= 0)
          check("r_data", 32'(rd_data), 32'(mem_m[(a + idx) % LEN]));
        check("r_last", 32'(rd_last), 32'(idx == len));
        if (stalled) check("r_stable", 32'(rd_data), 32'(prev));
        check("r_req_ready_low", 32'(req_ready), 32'(0));
        check("r_busy", 32'(busy), 32'(1));
      end else if (mode == 1) begin
        check("r_throughput", 32'(rd_valid), 32'(1));
      end
      case (mode)
        1:       rd_ready = 1'b1;
        2:       rd_ready = (k % 3 == 0);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      k++;
      stalled = rd_valid && !rd_ready;
      prev = rd_data;
      if (rd_valid && rd_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    check("r_count", 32'(idx), 32'(len + 1));
    check("r_valid_low", 32'(rd_valid), 32'(0));
    check("r_idle_ready", 32'(req_ready), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'(0));
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_rd_last"}, 32'(rd_last), 32'(0));
    check({tag, "_rd_data"}, 32'(rd_data), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < LEN; i++) mem_m[i] = -1;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;
    check("por_req_ready_rise", 32'(req_ready), 32'(1));

    // Fill the whole array so every later read has a known expectation.
    for (int i = 0; i < 7; i++) do_write(i * 16, 15, 0);

    // Directed write with gaps, then reads at full rate and with stalls.
    wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_write(16'h10, 3, 40);
    check("dir_mem10", 32'(mem_m[16]), 32'h A1);
    check("dir_mem13", 32'(mem_m[19]), 32'h A4);
    do_read(16'h10, 3, 1, 1'b0, 0, 0);
    do_read(16'h10, 3, 2, 1'b0, 0, 0);

    // Wrap from LEN-1 to 0, then modulo reduction of an out-of-range address.
    wq = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_write(98, 3, 0);
    check("wrap_mem0", 32'(mem_m[0]), 32'h03);
    do_read(98, 3, 1, 1'b0, 0, 0);
    do_write(205, 4, 20);
    do_read(5, 4, 3, 1'b0, 0, 0);
    do_read(0, 0, 2, 1'b0, 0, 0);

    // Reset after two beats of a four-beat write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(40); req_len = BW'(3);
    wait_accept("rst_accept");
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data = WS'(8'hC0 + i);
      @(posedge clk); #1;
      mem_m[40 + i] = 8'hC0 + i;
    end
    wr_data = 8'hEE;
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid");
    @(posedge clk); #1;
    wr_valid = 1'b0;
    reset = 1'b1;
    #1 check("mid_req_ready_rise", 32'(req_ready), 32'(1));
    do_read(40, 3, 1, 1'b0, 0, 0);

    // Back-to-back: read then write with req_valid held high throughout.
    do_read(16'h10, 3, 2, 1'b1, 60, 2);
    do_write(60, 2, 30);
    do_read(60, 2, 1, 1'b0, 0, 0);

    // Randomized mix of bursts.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1) == 1)
        do_write(int'($urandom_range(255)), int'($urandom_range(15)), int'($urandom_range(50)));
      else
        do_read(int'($urandom_range(255)), int'($urandom_range(15)), int'($urandom_range(3, 1)),
                1'b0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter LEN, default 65536, number of words stored.
REQ-003 SHALL have parameter ADDR_W, default 16, address width; ADDR_W >= ceil(log2(LEN)).
REQ-004 SHALL have parameter BURST_W, default 4, burst-length field width; max burst = 2**BURST_W words.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port req_valid  input  1  command offered.
REQ-008 SHALL have port req_ready  output  1  command accepted when req_valid && req_ready.
REQ-009 SHALL have port req_write  input  1  1 = write burst, 0 = read burst.
REQ-010 SHALL have port req_addr  input  ADDR_W  burst start address.
REQ-011 SHALL have port req_len  input  BURST_W  burst length minus one.
REQ-012 SHALL have port wr_valid / wr_ready  input / output  1 / 1  write-data handshake.
REQ-013 SHALL have port wr_data  input  WORD_SIZE  write word.
REQ-014 SHALL have port rd_valid / rd_ready  output / input  1 / 1  read-data handshake.
REQ-015 SHALL have port rd_data  output  WORD_SIZE  read word, held stable while rd_valid && !rd_ready.
REQ-016 SHALL have port rd_last  output  1  marks final word of a read burst.
REQ-017 SHALL have port busy  output  1  high whenever state != IDLE or rd_valid.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ.
REQ-019 IDLE: req_ready=1 only if rd_valid=0; on accept, latch addr, remaining count = req_len, go WRITE or READ per req_write.
REQ-020 WRITE: wr_ready=1; each wr_valid&&wr_ready writes wr_data to current addr at that clock edge, addr+1, count-1; after the (req_len+1)th beat return to IDLE.
REQ-021 wr_ready SHALL be 0 outside WRITE; wr_valid outside WRITE is ignored.
REQ-022 READ: one-entry output register; word at current addr loaded into rd_data when register empty or being drained (rd_valid&&rd_ready) in same cycle; addr+1, count-1 per load.
REQ-023 Read latency SHALL be 1 cycle: first rd_valid in cycle after command accept; full throughput 1 word/cycle with rd_ready held high.
REQ-024 rd_last SHALL be 1 with the word loaded when count==0; FSM returns IDLE on that load; rd_valid stays until consumed.
REQ-025 Address SHALL wrap from LEN-1 to 0 within a burst (not at 2**ADDR_W).
REQ-026 req_addr >= LEN SHALL be reduced modulo LEN on accept.
REQ-027 New command SHALL NOT be accepted in the cycle the last beat completes; earliest accept is next cycle in IDLE.
REQ-028 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-029 While reset=0: state=IDLE, req_ready=0, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0, counters=0.
REQ-030 Reset asserted mid-burst SHALL abort it immediately; words already written remain; unwritten words untouched.
REQ-031 req_ready SHALL rise in first cycle after reset deasserts.

Structure
REQ-032 Package burst_memory_pkg SHALL hold the state enumeration and default parameter constants.
REQ-033 Storage SHALL be one sub-module burst_memory_array (sync write, combinational read, WORD_SIZE x LEN, no reset).

Verification
REQ-034 Write burst addr 0x0010 len 3 data A1,A2,A3,A4 with wr_valid gaps -> exactly 4 writes, mem[0x10..0x13]=A1..A4, req_ready back after last beat.
REQ-035 Read burst addr 0x0010 len 3, rd_ready=1 -> rd_data A1..A4 on 4 consecutive cycles starting 1 cycle after accept, rd_last only on A4.
REQ-036 Same read with rd_ready toggled 1,0,0,1,... -> no word lost or duplicated, rd_data stable during stalls.
REQ-037 LEN=100: write addr 98 len 3 data 1,2,3,4 -> mem[98]=1, mem[99]=2, mem[0]=3, mem[1]=4.
REQ-038 Reset pulsed after 2nd beat of a 4-beat write -> outputs at reset values, 2 words written, remaining 2 locations unchanged, next command accepted.
REQ-039 req_valid held high back-to-back read then write -> second command accepted only after rd_last word consumed.
